// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcode classes, opcode constants, the decode bundle
// and the opcode classifier used by decode_stage.
package riscv_decode_pkg;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_OP,
        CLS_OP_IMM,
        CLS_LUI,
        CLS_AUIPC,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Width-independent part of the bundle; imm/pc live beside it at parameter width.
    typedef struct packed {
        op_class_e   cls;
        logic        illegal;
        logic [9:0]  funct;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } decode_bundle_t;

    function automatic op_class_e classify(logic [31:0] instr);
        op_class_e cls;
        case (instr[6:0])
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_OP:     cls = CLS_OP;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side signals of decode_stage. out_pred_taken_o exists only
// when DECODE_STAGE_BTFN_EN is defined.
interface decode_stage_if
    import riscv_decode_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    logic [31:0]               instr_i;
    logic [ADDR_WIDTH-1:0]     pc_i;
    logic                      instr_valid_i;
    logic                      instr_req_o;
    logic [ADDR_WIDTH-1:0]     target_addr_o;
    logic                      target_valid_o;
    logic                      out_valid_o;
    logic                      out_ready_i;
    op_class_e                 out_class_o;
    logic [XLEN-1:0]           out_imm_o;
    logic [REG_ADDR_WIDTH-1:0] out_rs1_o;
    logic [REG_ADDR_WIDTH-1:0] out_rs2_o;
    logic [REG_ADDR_WIDTH-1:0] out_rd_o;
    logic [9:0]                out_funct_o;
    logic [ADDR_WIDTH-1:0]     out_pc_o;
    logic                      out_illegal_o;
`ifdef DECODE_STAGE_BTFN_EN
    logic                      out_pred_taken_o;
`endif

    // master: the decode stage itself; slave: fetch/execute environment.
    modport master (
        input  instr_i, pc_i, instr_valid_i, out_ready_i,
        output instr_req_o, target_addr_o, target_valid_o, out_valid_o, out_class_o,
        output out_imm_o, out_rs1_o, out_rs2_o, out_rd_o, out_funct_o, out_pc_o,
        output out_illegal_o
`ifdef DECODE_STAGE_BTFN_EN
        , output out_pred_taken_o
`endif
    );

    modport slave (
        output instr_i, pc_i, instr_valid_i, out_ready_i,
        input  instr_req_o, target_addr_o, target_valid_o, out_valid_o, out_class_o,
        input  out_imm_o, out_rs1_o, out_rs2_o, out_rd_o, out_funct_o, out_pc_o,
        input  out_illegal_o
`ifdef DECODE_STAGE_BTFN_EN
        , input out_pred_taken_o
`endif
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J immediate for the
// instruction class and sign-extends it to XLEN.
module imm_gen
    import riscv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  op_class_e       cls_i,
    output logic [XLEN-1:0] imm_o
);
    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (cls_i)
            CLS_LOAD, CLS_OP_IMM, CLS_JALR, CLS_SYSTEM:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            CLS_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            CLS_BRANCH:
                imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            CLS_JAL:
                imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with JAL redirect and wrong-path flush.
// Define DECODE_STAGE_BTFN_EN to also redirect on backward conditional branches.
module decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FLUSH_DEPTH    = 1
) (
    input logic            clk,
    input logic            rst_n,
    decode_stage_if.master bus
);
    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_DEPTH);

    state_e                state_q, state_d;
    logic [2:0]            flush_cnt_q, flush_cnt_d;
    decode_bundle_t        bundle_q, bundle_d;
    logic [XLEN-1:0]       imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  out_valid_q, out_valid_d;
    logic                  target_valid_q, target_valid_d;
    logic                  pred_q, pred_d;

    op_class_e       cls;
    logic [XLEN-1:0] imm;
    logic            instr_req;
    logic            accept;
    logic            bwd_branch;
    logic            redirect;

    assign cls = classify(bus.instr_i);

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr_i (bus.instr_i),
        .cls_i   (cls),
        .imm_o   (imm)
    );

    // While flushing, fetch is always drained so wrong-path words never stall it.
    assign instr_req = (state_q == StRun) ? (!out_valid_q || bus.out_ready_i) : 1'b1;
    assign accept    = bus.instr_valid_i && instr_req && (state_q == StRun);

`ifdef DECODE_STAGE_BTFN_EN
    assign bwd_branch = (cls == CLS_BRANCH) && bus.instr_i[31];
`else
    assign bwd_branch = 1'b0;
`endif
    assign redirect = (cls == CLS_JAL) || bwd_branch;

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        bundle_d       = bundle_q;
        imm_d          = imm_q;
        pc_d           = pc_q;
        target_d       = target_q;
        out_valid_d    = out_valid_q;
        target_valid_d = 1'b0;
        pred_d         = pred_q;

        case (state_q)
            StRun: begin
                if (accept && redirect) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (accept) begin
            out_valid_d      = 1'b1;
            bundle_d.cls     = cls;
            bundle_d.illegal = (cls == CLS_ILLEGAL) || (bus.instr_i[1:0] != 2'b11);
            bundle_d.funct   = {bus.instr_i[31:25], bus.instr_i[14:12]};
            bundle_d.rs1     = bus.instr_i[19:15];
            bundle_d.rs2     = bus.instr_i[24:20];
            bundle_d.rd      = bus.instr_i[11:7];
            imm_d            = imm;
            pc_d             = bus.pc_i;
            pred_d           = bwd_branch;
            if (redirect) begin
                target_valid_d = 1'b1;
                target_d       = bus.pc_i + ADDR_WIDTH'($signed(imm));
            end
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRun;
            flush_cnt_q    <= '0;
            bundle_q       <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            target_q       <= '0;
            out_valid_q    <= 1'b0;
            target_valid_q <= 1'b0;
            pred_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            bundle_q       <= bundle_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
            target_q       <= target_d;
            out_valid_q    <= out_valid_d;
            target_valid_q <= target_valid_d;
            pred_q         <= pred_d;
        end
    end

    assign bus.instr_req_o    = instr_req;
    assign bus.target_addr_o  = target_q;
    assign bus.target_valid_o = target_valid_q;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_class_o    = bundle_q.cls;
    assign bus.out_imm_o      = imm_q;
    assign bus.out_rs1_o      = REG_ADDR_WIDTH'(bundle_q.rs1);
    assign bus.out_rs2_o      = REG_ADDR_WIDTH'(bundle_q.rs2);
    assign bus.out_rd_o       = REG_ADDR_WIDTH'(bundle_q.rd);
    assign bus.out_funct_o    = bundle_q.funct;
    assign bus.out_pc_o       = pc_q;
    assign bus.out_illegal_o  = bundle_q.illegal;
`ifdef DECODE_STAGE_BTFN_EN
    assign bus.out_pred_taken_o = pred_q;
`else
    logic unused_pred;
    assign unused_pred = pred_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by random traffic
// checked every cycle against a transaction-level reference model.
module tb_decode_stage;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned ADDR_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned FLUSH_DEPTH    = 1;

    // Class codes in declaration order of op_class_e.
    localparam int C_LOAD = 0, C_STORE = 1, C_BRANCH = 2, C_JAL = 3, C_JALR = 4, C_OP = 5;
    localparam int C_OP_IMM = 6, C_LUI = 7, C_AUIPC = 8, C_SYSTEM = 9, C_ILLEGAL = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_stage_if #(
        .XLEN           (XLEN),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) bus ();

    decode_stage #(
        .XLEN           (XLEN),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .FLUSH_DEPTH    (FLUSH_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: what execute/fetch should currently be seeing.
    logic        m_vld, m_tv, m_ill, m_pred;
    logic [31:0] m_ta, m_imm, m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [9:0]  m_funct;
    int          m_cls;
    int          m_flush;

    logic [6:0] opc_tab [12] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33,
                                 7'h13, 7'h37, 7'h17, 7'h73, 7'h6F, 7'h63};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_tv = 0; m_ill = 0; m_pred = 0; m_ta = 0; m_imm = 0; m_pc = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0; m_cls = 0; m_flush = 0;
    endtask

    function automatic int ref_class(input logic [31:0] ins);
        case (ins[6:0])
            7'h03: return C_LOAD;
            7'h23: return C_STORE;
            7'h63: return C_BRANCH;
            7'h6F: return C_JAL;
            7'h67: return C_JALR;
            7'h33: return C_OP;
            7'h13: return C_OP_IMM;
            7'h37: return C_LUI;
            7'h17: return C_AUIPC;
            7'h73: return C_SYSTEM;
            default: return C_ILLEGAL;
        endcase
    endfunction

    // Immediates rebuilt with signed integer arithmetic on the instruction word.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input int cls);
        int s;
        s = $signed(ins);
        case (cls)
            C_LOAD, C_JALR, C_OP_IMM, C_SYSTEM: return s >>> 20;
            C_STORE: return ((s >>> 25) * 32) + int'(ins[11:7]);
            C_BRANCH: return ((s >>> 31) * 4096) + int'(ins[7]) * 2048
                             + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            C_JAL: return ((s >>> 31) * 1048576) + int'(ins[19:12]) * 4096
                          + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            C_LUI, C_AUIPC: return ins & 32'hFFFF_F000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_redirect(input logic [31:0] ins, input int cls);
`ifdef DECODE_STAGE_BTFN_EN
        return (cls == C_JAL) || (cls == C_BRANCH && ins[31]);
`else
        return (cls == C_JAL) && (ins !== 32'hx);
`endif
    endfunction

    task automatic check_all(input logic rdy);
        check_eq("instr_req", 32'(bus.instr_req_o), 32'((m_flush > 0) || !m_vld || rdy));
        check_eq("out_valid", 32'(bus.out_valid_o), 32'(m_vld));
        check_eq("target_valid", 32'(bus.target_valid_o), 32'(m_tv));
        if (m_tv) check_eq("target_addr", bus.target_addr_o, m_ta);
        if (m_vld) begin
            check_eq("class", 32'(bus.out_class_o), m_cls);
            check_eq("imm", bus.out_imm_o, m_imm);
            check_eq("rs1", 32'(bus.out_rs1_o), 32'(m_rs1));
            check_eq("rs2", 32'(bus.out_rs2_o), 32'(m_rs2));
            check_eq("rd", 32'(bus.out_rd_o), 32'(m_rd));
            check_eq("funct", 32'(bus.out_funct_o), 32'(m_funct));
            check_eq("pc", bus.out_pc_o, m_pc);
            check_eq("illegal", 32'(bus.out_illegal_o), 32'(m_ill));
`ifdef DECODE_STAGE_BTFN_EN
            check_eq("pred_taken", 32'(bus.out_pred_taken_o), 32'(m_pred));
`endif
        end
    endtask

    // One clock: drive on the falling edge, check, then advance the model on the rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy);
        logic acc;
        int   cls;
        @(negedge clk);
        bus.instr_valid_i = v;
        bus.instr_i       = ins;
        bus.pc_i          = pc;
        bus.out_ready_i   = rdy;
        #1;
        check_all(rdy);
        @(posedge clk);
        acc = v && (m_flush == 0) && (!m_vld || rdy);
        if (m_flush > 0) m_flush--;
        m_tv = 0;
        if (acc) begin
            cls     = ref_class(ins);
            m_vld   = 1;
            m_cls   = cls;
            m_imm   = ref_imm(ins, cls);
            m_pc    = pc;
            m_rs1   = ins[19:15];
            m_rs2   = ins[24:20];
            m_rd    = ins[11:7];
            m_funct = {ins[31:25], ins[14:12]};
            m_ill   = (cls == C_ILLEGAL);
            m_pred  = (cls == C_BRANCH) && ref_redirect(ins, cls);
            if (ref_redirect(ins, cls)) begin
                m_tv    = 1;
                m_ta    = pc + m_imm;
                m_flush = FLUSH_DEPTH;
            end
        end else if (rdy) begin
            m_vld = 0;
        end
    endtask

    initial begin
        logic [31:0] ins;
        int          k;
        bus.instr_valid_i = 0;
        bus.instr_i       = 0;
        bus.pc_i          = 0;
        bus.out_ready_i   = 0;
        model_reset();

        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid_o), 0);
        check_eq("rst_target_valid", 32'(bus.target_valid_o), 0);
        check_eq("rst_instr_req", 32'(bus.instr_req_o), 1);
        check_eq("rst_imm", bus.out_imm_o, 0);
        rst_n = 1'b1;

        // addi x1,x2,-1
        step(1, 32'hFFF1_0093, 32'h40, 1);
        #2;
        check_eq("addi_valid", 32'(bus.out_valid_o), 1);
        check_eq("addi_class", 32'(bus.out_class_o), C_OP_IMM);
        check_eq("addi_imm", bus.out_imm_o, 32'hFFFF_FFFF);
        check_eq("addi_rs1", 32'(bus.out_rs1_o), 2);
        check_eq("addi_rd", 32'(bus.out_rd_o), 1);
        check_eq("addi_pc", bus.out_pc_o, 32'h40);
        check_eq("addi_tv", 32'(bus.target_valid_o), 0);

        // jal x0,8 then a wrong-path nop that must be dropped
        step(1, 32'h0080_006F, 32'h100, 1);
        #2;
        check_eq("jal_tv", 32'(bus.target_valid_o), 1);
        check_eq("jal_target", bus.target_addr_o, 32'h108);
        step(1, 32'h0000_0013, 32'h104, 1);
        #2;
        check_eq("jal_pulse_end", 32'(bus.target_valid_o), 0);
        check_eq("flush_dropped", 32'(bus.out_valid_o), 0);
        step(1, 32'h0000_0013, 32'h108, 1);
        #2;
        check_eq("post_flush_valid", 32'(bus.out_valid_o), 1);
        check_eq("post_flush_pc", bus.out_pc_o, 32'h108);

        // beq x0,x0,-4
        step(1, 32'hFE00_0EE3, 32'h200, 1);
        #2;
        check_eq("beq_imm", bus.out_imm_o, 32'hFFFF_FFFC);
`ifdef DECODE_STAGE_BTFN_EN
        check_eq("beq_tv", 32'(bus.target_valid_o), 1);
        check_eq("beq_target", bus.target_addr_o, 32'h1FC);
        check_eq("beq_pred", 32'(bus.out_pred_taken_o), 1);
`else
        check_eq("beq_tv", 32'(bus.target_valid_o), 0);
`endif
        step(0, 32'h0, 32'h0, 1);

        // Back-pressure: bundle must hold for three stalled cycles
        step(1, 32'hFFF1_0093, 32'h300, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0041_8193 + 32'(i), 32'h304 + 32'(4 * i), 0);
            #2;
            check_eq("bp_req", 32'(bus.instr_req_o), 0);
            check_eq("bp_pc_hold", bus.out_pc_o, 32'h300);
            check_eq("bp_imm_hold", bus.out_imm_o, 32'hFFFF_FFFF);
        end
        step(1, 32'h0041_8193, 32'h310, 1);
        #2;
        check_eq("bp_release_pc", bus.out_pc_o, 32'h310);

        // Illegal opcode
        step(1, 32'h0000_007F, 32'h320, 1);
        #2;
        check_eq("ill_flag", 32'(bus.out_illegal_o), 1);
        check_eq("ill_class", 32'(bus.out_class_o), C_ILLEGAL);
        check_eq("ill_tv", 32'(bus.target_valid_o), 0);

        // Reset while flushing
        step(1, 32'h0080_006F, 32'h400, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_flush_tv", 32'(bus.target_valid_o), 0);
        check_eq("rst_flush_ov", 32'(bus.out_valid_o), 0);
        check_eq("rst_flush_ta", bus.target_addr_o, 0);
        check_eq("rst_flush_pc", bus.out_pc_o, 0);
        check_eq("rst_flush_req", 32'(bus.instr_req_o), 1);
        model_reset();
        rst_n = 1'b1;
        step(1, 32'hFFF1_0093, 32'h500, 1);
        #2;
        check_eq("rst_run_accept", 32'(bus.out_valid_o), 1);
        check_eq("rst_run_pc", bus.out_pc_o, 32'h500);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 12);
            ins = $urandom();
            if (k < 12) ins[6:0] = opc_tab[k];
            step($urandom_range(0, 9) < 7, ins, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0);
        end
        step(0, 32'h0, 32'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I decode stage between fetch and execute.
- Accepts an instruction/PC pair from fetch over a valid/ready handshake and extracts register addresses and the sign-extended immediate for every format.
- Classifies the opcode and emits a registered decode bundle downstream.
- Resolves JAL (and optionally backward conditional branches) at decode, redirecting fetch and squashing wrong-path instructions.

Parameters:
- XLEN, 32, data/immediate width; immediates sign-extended to XLEN.
- ADDR_WIDTH, 32, PC and target width.
- REG_ADDR_WIDTH, 5, register address width (6 supported for extended register files; upper bit zero-filled).
- FLUSH_DEPTH, 1, cycles of wrong-path input dropped after a redirect (1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- instr_i  in  32  instruction word from fetch
- pc_i  in  ADDR_WIDTH  PC of instr_i
- instr_valid_i  in  1  instr_i/pc_i valid
- instr_req_o  out  1  decode ready; fetch may present next instruction
- target_addr_o  out  ADDR_WIDTH  redirect target
- target_valid_o  out  1  one-cycle redirect pulse
- out_valid_o  out  1  decode bundle valid
- out_ready_i  in  1  execute accepts bundle
- out_class_o  out  4  opcode class (op_class_e)
- out_imm_o  out  XLEN  selected immediate
- out_rs1_o, out_rs2_o, out_rd_o  out  REG_ADDR_WIDTH each  register addresses
- out_funct_o  out  10  {funct7, funct3}
- out_pc_o  out  ADDR_WIDTH  PC of bundled instruction
- out_illegal_o  out  1  opcode not recognised, or instr_i[1:0] != 2'b11

Behaviour:
- Reset: every output and internal register is 0; state is RUN; flush counter is 0.
- instr_req_o = (state==RUN) ? (!out_valid_o || out_ready_i) : 1.
- Accept occurs when instr_valid_i && instr_req_o && state==RUN. The bundle is registered on accept, giving 1-cycle latency.
- When no accept occurs and out_ready_i is high, out_valid_o clears. The bundle holds stable while out_valid_o && !out_ready_i.
- Immediate selection by class:
  - I-type: LOAD, OP_IMM, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - OP: 0.
  - All immediates are sign-extended from instr_i[31]; U-type is {instr_i[31:12], 12'b0} sign-extended to XLEN.
- Target computation uses pc_i + imm, with ADDR_WIDTH wrap-around (no overflow flag).
- On accept of a JAL:
  - target_addr_o <= pc_i + imm_J and target_valid_o <= 1 for exactly one cycle (the cycle after accept).
  - State moves to FLUSH and the counter loads FLUSH_DEPTH.
- FLUSH state:
  - Any instr_valid_i is consumed and discarded; no bundle is produced.
  - The counter decrements each cycle and the state returns to RUN when it reaches 0.
  - out_valid_o/bundle handshake with execute continues normally.
- JALR, conditional branches (without the optional feature), and illegal instructions pass through without a redirect. Illegal instructions carry out_illegal_o=1 with out_class_o=CLS_ILLEGAL.
- Back-to-back: an accept in the cycle a redirect issues is impossible, because state is already FLUSH.
- Reset mid-FLUSH returns to RUN with target_valid_o=0 and out_valid_o=0.

Optional Feature:
- Macro: DECODE_STAGE_BTFN_EN.
- Defined: a conditional branch whose instr_i[31]=1 (backward) is predicted taken and redirects exactly like JAL, with target pc_i + imm_B.
  - The bundle bit out_funct_o is unchanged.
  - An extra output out_pred_taken_o (1 bit, reset 0) flags the prediction for execute to verify.
- Undefined: branches never redirect and out_pred_taken_o does not exist.

Decomposition:
- Shared package riscv_decode_pkg holds:
  - op_class_e (CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_ILLEGAL).
  - Opcode constants (7'b0000011 ... 7'b1110011).
  - The decode_bundle_t struct.
- One combinational sub-module, imm_gen, takes instr and class and returns the XLEN immediate.
- decode_stage keeps the FSM, flush counter and output registers.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), pc 0x40, out_ready_i=1 -> next cycle out_valid_o=1, class OP_IMM, imm 0xFFFFFFFF, rs1=2, rd=1, pc 0x40, target_valid_o=0.
- jal x0,8 (0x0080006F) at pc 0x100, followed by 0x00000013 presented the next cycle -> target_valid_o=1 for one cycle with target_addr_o=0x108; the following instruction is dropped (FLUSH_DEPTH=1); the next valid instruction is accepted normally.
- beq x0,x0,-4 (0xFE000EE3) at pc 0x200 -> with the macro: redirect to 0x1FC and out_pred_taken_o=1. Without it: no redirect, imm 0xFFFFFFFC.
- Back-pressure: out_ready_i=0 for 3 cycles with valid input -> instr_req_o=0, bundle held bit-stable; one accept after out_ready_i rises.
- Illegal opcode 0x0000007F -> out_illegal_o=1, class CLS_ILLEGAL, no redirect.
- Assert rst_n low during FLUSH -> all outputs 0 immediately; after release, instr_req_o=1 and state is RUN.
